// File: rtl/irig_event_stamp.sv
// irig_event_stamp
// Timestamps rising edges of an asynchronous event strobe against the current
// IRIG time and queues the 64-bit words in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   en                capture enable (0 forces IDLE)
//   event_in          asynchronous event strobe, rising edge = capture request
//   sec, min, hr, day current time fields from the IRIG time stage
//   subsec            clk cycles since the last pps
//   bcd_valid         time fields are locked and valid
//   m_tdata/m_tvalid  FIFO head word / FIFO not empty
//   m_tready          consumer accepts the head word
//   level             FIFO occupancy, 0..DEPTH
//   drop_count        saturating count of events lost to a full FIFO
//   state_out         FSM state: IDLE=0, ARMED=1, HOLD=2
module irig_event_stamp #(
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        event_in,
    input  logic [5:0]  sec,
    input  logic [5:0]  min,
    input  logic [4:0]  hr,
    input  logic [8:0]  day,
    input  logic [31:0] subsec,
    input  logic        bcd_valid,
    output logic [63:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [6:0]  level,
    output logic [15:0] drop_count,
    output logic [1:0]  state_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [6:0]    LVL_FULL  = 7'(DEPTH);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_hist;
    logic [1:0]      r_warm;
    logic [63:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [6:0]      r_level;
    logic            r_valid;
    logic [15:0]     r_drop;

    logic            w_rise;
    logic            w_cap;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [63:0]     w_word;
    logic [6:0]      w_level_nxt;

    // Synchronizer, history flop and post-reset warm-up counter.
    // The warm-up counter masks detection until the synchronizer holds two
    // genuine post-reset samples, so a level held high through reset release
    // is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_warm  <= 2'd0;
        end else begin
            r_sync1 <= event_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_warm  <= (r_warm == 2'd3) ? r_warm : (r_warm + 2'd1);
        end
    end

    // Detection, capture decision and next FIFO occupancy.
    always_comb begin
        w_rise = r_sync2 & ~r_hist & (r_warm == 2'd3);
        w_cap  = (r_state == ST_ARMED) & w_rise;
        w_full = (r_level == LVL_FULL);
        w_pop  = r_valid & m_tready;
        // A full FIFO still accepts the word when the head leaves this cycle.
        w_push = w_cap & (~w_full | w_pop);
        w_drop = w_cap & ~w_push;
        w_word = {bcd_valid, 5'b00000, day, hr, min, sec, subsec};
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 7'd1;
            2'b01:   w_level_nxt = r_level - 7'd1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Capture FSM with holdoff counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (!en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= HOLD_LOAD;
                    end else begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ARMED;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // FIFO pointers, occupancy, valid flag and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= 7'd0;
            r_valid <= 1'b0;
            r_drop  <= 16'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != 7'd0);
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign m_tdata    = r_mem[r_rptr];
    assign m_tvalid   = r_valid;
    assign level      = r_level;
    assign drop_count = r_drop;
    assign state_out  = r_state;

endmodule

// File: tb/tb_irig_event_stamp.sv
// Testbench for irig_event_stamp (DEPTH=8, HOLDOFF=16).
// A table of time-field vectors with hand-computed words is applied first,
// then hand-written sequences cover holdoff, FIFO full/drop, pop-while-full,
// reset mid-HOLD, level held through reset, and en dropped on a capture.
module tb_irig_event_stamp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        event_in;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hr;
    logic [8:0]  day;
    logic [31:0] subsec;
    logic        bcd_valid;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [6:0]  level;
    logic [15:0] drop_count;
    logic [1:0]  state_out;

    int n_vec = 0;
    int n_err = 0;

    irig_event_stamp #(.DEPTH(8), .HOLDOFF(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .event_in   (event_in),
        .sec        (sec),
        .min        (min),
        .hr         (hr),
        .day        (day),
        .subsec     (subsec),
        .bcd_valid  (bcd_valid),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .level      (level),
        .drop_count (drop_count),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bv;
        logic [8:0]  dy;
        logic [4:0]  hh;
        logic [5:0]  mm;
        logic [5:0]  ss;
        logic [31:0] s;
        logic [63:0] exp_word;
    } vec_t;

    vec_t vecs [5];

    // One clock; sample point is 1 ns after the rising edge, subsec free-runs.
    task automatic tick();
        @(posedge clk);
        #1;
        subsec = subsec + 32'd1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // subsec is s one cycle before event_in rises; the rise is detected in the
    // cycle ending at the 3rd edge, where subsec has reached s+3. Returns just
    // after that capture edge.
    task automatic fire(input logic [31:0] s, input logic rdy_at_cap);
        subsec = s;
        tick();
        event_in = 1'b1;
        tick();
        tick();
        if (rdy_at_cap) begin
            m_tready = 1'b1;
            tick();
            m_tready = 1'b0;
        end else begin
            tick();
        end
        event_in = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 9'd100, 5'd12, 6'd34, 6'd56, 32'd1000,       64'h80C8C8B8_000003EB};
        vecs[1] = '{1'b0, 9'd365, 5'd23, 6'd59, 6'd59, 32'd0,          64'h02DB7EFB_00000003};
        vecs[2] = '{1'b1, 9'd1,   5'd0,  6'd0,  6'd0,  32'hFFFF_FFFC,  64'h80020000_FFFFFFFF};
        vecs[3] = '{1'b1, 9'd511, 5'd31, 6'd63, 6'd63, 32'h1234_5670,  64'h83FFFFFF_12345673};
        vecs[4] = '{1'b0, 9'd100, 5'd12, 6'd34, 6'd56, 32'd500,        64'h00C8C8B8_000001F7};

        rst = 1'b1; en = 1'b0; event_in = 1'b0; m_tready = 1'b0;
        sec = 6'd0; min = 6'd0; hr = 5'd0; day = 9'd0; subsec = 32'd0; bcd_valid = 1'b0;
        repeat (3) tick();
        chk("rst_state", 64'(state_out), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);

        rst = 1'b0; en = 1'b1;
        tick();
        chk("armed_after_en", 64'(state_out), 64'd1);
        repeat (3) tick();

        // Table: one capture per vector, popped immediately by m_tready=1.
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bcd_valid = vecs[i].bv; day = vecs[i].dy; hr = vecs[i].hh;
            min = vecs[i].mm; sec = vecs[i].ss;
            fire(vecs[i].s, 1'b0);
            chk($sformatf("vec%0d_word", i), m_tdata, vecs[i].exp_word);
            chk($sformatf("vec%0d_tvalid", i), 64'(m_tvalid), 64'd1);
            chk($sformatf("vec%0d_level", i), 64'(level), 64'd1);
            chk($sformatf("vec%0d_state", i), 64'(state_out), 64'd2);
            repeat (20) tick();
            chk($sformatf("vec%0d_drained", i), 64'(level), 64'd0);
            chk($sformatf("vec%0d_rearmed", i), 64'(state_out), 64'd1);
        end

        bcd_valid = 1'b1; day = 9'd100; hr = 5'd12; min = 6'd34; sec = 6'd56;

        // Holdoff: second rise 10 cycles after the first is ignored.
        m_tready = 1'b0;
        fire(32'd50, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("hold_state_c%0d", i), 64'(state_out), 64'd2);
            if (i == 7) event_in = 1'b1;
            if (i == 10) event_in = 1'b0;
            tick();
        end
        chk("hold_end_state", 64'(state_out), 64'd1);
        chk("hold_one_word", 64'(level), 64'd1);
        chk("hold_no_drop", 64'(drop_count), 64'd0);
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        chk("hold_flushed", 64'(level), 64'd0);

        // Ten events, no consumer: 8 stored, 2 dropped, head is the first.
        for (int k = 0; k < 10; k++) begin
            fire(32'd2000 + 32'(k) * 32'd100, 1'b0);
            repeat (16) tick();
        end
        chk("full_level", 64'(level), 64'd8);
        chk("full_drop", 64'(drop_count), 64'd2);
        chk("full_head", m_tdata, 64'h80C8C8B8_000007D3);
        chk("full_tvalid", 64'(m_tvalid), 64'd1);
        chk("full_state", 64'(state_out), 64'd1);

        // Full FIFO, pop in the detection cycle: push accepted, no drop.
        fire(32'd2900, 1'b1);
        chk("popfull_level", 64'(level), 64'd8);
        chk("popfull_drop", 64'(drop_count), 64'd2);
        chk("popfull_head", m_tdata, 64'h80C8C8B8_00000837);
        repeat (16) tick();

        // Reset mid-HOLD with 5 entries, event_in held high through release.
        m_tready = 1'b1;
        repeat (4) tick();
        m_tready = 1'b0;
        chk("pre_rst_level4", 64'(level), 64'd4);
        fire(32'd3000, 1'b0);
        chk("pre_rst_level5", 64'(level), 64'd5);
        chk("pre_rst_hold", 64'(state_out), 64'd2);
        rst = 1'b1;
        event_in = 1'b1;
        tick();
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_state", 64'(state_out), 64'd0);
        chk("midrst_drop", 64'(drop_count), 64'd0);
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("held_high_no_cap", 64'(level), 64'd0);
        chk("held_high_state", 64'(state_out), 64'd1);

        // en dropped in the capture cycle: word still stored, FSM to IDLE.
        event_in = 1'b0;
        repeat (3) tick();
        subsec = 32'd4000;
        event_in = 1'b1;
        tick();
        tick();
        en = 1'b0;
        tick();
        chk("en_off_state", 64'(state_out), 64'd0);
        chk("en_off_level", 64'(level), 64'd1);
        chk("en_off_word", m_tdata, 64'h80C8C8B8_00000FA2);
        event_in = 1'b0;
        repeat (3) tick();
        event_in = 1'b1;
        repeat (4) tick();
        chk("idle_ignores", 64'(level), 64'd1);
        chk("idle_stays", 64'(state_out), 64'd0);
        en = 1'b1;
        tick();
        chk("idle_to_armed", 64'(state_out), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
